logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters in the single-cycle processor: the main datapath (requester 0) and the debug/test port (requester 1).
- Arbitrates between them round-robin and registers the operands.
- Sequences a fixed 3-state operation and returns the result over a per-requester valid/ready response handshake.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  2  requester 0 opcode.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_op  input  2  requester 1 opcode.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 takes the result.
- rsp1_valid  output  1  result available for requester 1.
- rsp1_ready  input  1  requester 1 takes the result.
- rsp_data  output  WIDTH  result, shared by both requesters.
- rsp_zero  output  1  high when rsp_data is all zeros.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - prio = 0 (requester 0 preferred).
  - Operand, op and result registers = 0.
  - rsp0_valid = rsp1_valid = 0; busy = 0; rsp_data = 0; rsp_zero = 1.
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NOR (bitwise, full WIDTH, no carry, no flags other than rsp_zero).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if only one reqN_valid is high, grant that requester. If both are high, grant requester prio.
  - reqN_ready = (state==IDLE) & grantN. This is combinational from the valids; at most one ready is high per cycle.
  - On a grant, latch a, b, op and the granted id, then go to EXEC.
  - With no valid, stay in IDLE.
- EXEC:
  - One cycle. The shared logic unit computes on the latched operands.
  - Result and rsp_zero are registered at the end of the cycle. Go to RESP.
- RESP:
  - rspN_valid = 1 for the latched id only; the other response valid stays 0.
  - rsp_data and rsp_zero are held stable.
  - When rspN_ready is high: prio <= ~id, go to IDLE.
  - No new request is accepted while in RESP.
- Latency: acceptance in cycle N; rsp_valid is high from cycle N+2. The earliest next acceptance is the cycle after the response handshake. Best-case throughput is one operation per 3 cycles.
- Requester rules:
  - reqN_valid and its operands must stay stable until reqN_ready.
  - Once asserted, reqN_valid must not be withdrawn.
  - rspN_ready may be held high in advance; the handshake then completes in the first RESP cycle.
- Simultaneous events:
  - Both requesters valid in IDLE: prio wins; the loser is served in the next IDLE.
  - Because prio flips after every completed operation, back-to-back contention alternates 0,1,0,1.
- Fairness: no requester waits for more than one other operation.
- rsp_data after the handshake: holds its last value until the next EXEC overwrites it.
- Reset mid-operation: rst_n low in any state returns immediately to the reset values. The in-flight operation is dropped with no response.
- Illegal state encodings: recover to IDLE.

Decomposition:
- Shared package logic_unit_pkg:
  - Opcode constants OP_AND, OP_OR, OP_XOR, OP_NOR.
  - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP.
  - Requester id constants.
- Sub-module: logic_unit_w, the purely combinational WIDTH-bit bitwise unit selected by op, instantiated exactly once inside the arbiter.
- The arbiter holds all sequential logic: FSM, round-robin prio, operand and result registers.

Test Plan:
- Reset then idle: rst_n low, then high with no valids -> busy=0, both ready=0, both rsp_valid=0, rsp_zero=1 for 10 cycles.
- Single XOR from requester 0: a=32'hFFFF0000, b=32'h0F0F0F0F, op=10, rsp0_ready held high ->
  - req0_ready pulses in cycle N.
  - rsp0_valid is high in cycle N+2 with rsp_data=32'hF0F00F0F, rsp_zero=0.
  - rsp1_valid stays 0.
- Contention and fairness: both requesters valid continuously, req0 op=00 (AND), req1 op=11 (NOR), a=b=32'h0 ->
  - Grant order 0,1,0,1.
  - Requester 0 results are 32'h0 with rsp_zero=1.
  - Requester 1 results are 32'hFFFFFFFF.
- Response backpressure: requester 1 OR of 32'h1 and 32'h2, rsp1_ready low for 5 cycles ->
  - rsp1_valid and rsp_data=32'h3 held stable for all 5 cycles.
  - req0_ready stays 0 throughout, even with req0_valid high.
  - Completion occurs in the cycle rsp1_ready rises.
- Reset mid-operation: rst_n asserted in EXEC ->
  - state=IDLE, busy=0, no rsp_valid after release.
  - The next request from requester 0 is granted first (prio=0).

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the two-requester bitwise logic unit arbiter:
// opcodes, FSM state encoding and requester ids.
package logic_unit_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   // Encoding 2'b11 is unused; the arbiter recovers from it to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam logic REQ_ID0 = 1'b0;  // main datapath
   localparam logic REQ_ID1 = 1'b1;  // debug/test port

endpackage

// File: rtl/logic_unit_w.sv
// Purely combinational WIDTH-bit bitwise unit (AND/OR/XOR/NOR) selected by op.
module logic_unit_w
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y
);

   // Bitwise operation select; no carries, no flags.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Each operation runs IDLE (accept) -> EXEC (compute) -> RESP (return).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. reqN_ready is combinational from the valids and only high in
// IDLE; rspN_valid is high only in RESP for the granted requester, and the
// response completes on the edge where rspN_ready is also high.
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             busy
);

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] lu_y;
   logic             grant0, grant1;

   logic_unit_w #(.WIDTH(WIDTH)) u_lu (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (lu_y)
   );

   // Grant: a lone requester wins; on contention the prio requester wins.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | (prio_q == REQ_ID0));
      grant1 = req1_valid & (~req0_valid | (prio_q == REQ_ID1));
   end

   // Next-state and handshake outputs; every register holds by default.
   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      id_d       = id_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      result_d   = result_q;
      zero_d     = zero_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0) begin
               id_d    = REQ_ID0;
               a_d     = req0_a;
               b_d     = req0_b;
               op_d    = req0_op;
               state_d = ST_EXEC;
            end else if (grant1) begin
               id_d    = REQ_ID1;
               a_d     = req1_a;
               b_d     = req1_b;
               op_d    = req1_op;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = lu_y;
            zero_d   = (lu_y == '0);
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            rsp0_valid = (id_q == REQ_ID0);
            rsp1_valid = (id_q == REQ_ID1);
            if ((id_q == REQ_ID0) ? rsp0_ready : rsp1_ready) begin
               prio_d  = ~id_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, round-robin pointer, operand and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         prio_q   <= REQ_ID0;
         id_q     <= REQ_ID0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign rsp_data = result_q;
   assign rsp_zero = zero_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (grant rule, fixed latency,
// result queue).
module tb_logic_unit_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]   req0_op, req1_op;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_zero, busy;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];

   logic_unit_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero),
      .busy       (busy)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_logic(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
             rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_zero !== 1'b1 ||
             rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d busy=%b rdy=%b%b rspv=%b%b zero=%b data=%h (want 0 00 00 1 0)",
                     i, busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_data);
         end
      end
   endtask

   task automatic test_single_xor();
      tick();
      req0_valid = 1'b1; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F; req0_op = 2'b10;
      rsp0_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL xor_accept rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL xor_exec busy=%b rspv0=%b rdy0=%b want 1 0 0", busy, rsp0_valid, req0_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'hF0F00F0F || rsp_zero !== 1'b0) begin
         failures++;
         $display("FAIL xor_resp rspv=%b%b data=%h zero=%b want 10 f0f00f0f 0",
                  rsp0_valid, rsp1_valid, rsp_data, rsp_zero);
      end
      tick();
      rsp0_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp_data !== 32'hF0F00F0F) begin
         failures++;
         $display("FAIL xor_after busy=%b rspv0=%b data=%h want 0 0 f0f00f0f", busy, rsp0_valid, rsp_data);
      end
   endtask

   task automatic test_contention();
      int  budget;
      bit  want_id;
      apply_reset();
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 2'b00;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 2'b11;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         want_id = k[0];
         budget = 0;
         @(negedge clk);
         while (!(req0_ready || req1_ready) && budget < 10) begin
            tick(); @(negedge clk); budget++;
         end
         checks++;
         if (req0_ready !== !want_id || req1_ready !== want_id) begin
            failures++;
            $display("FAIL contention_grant k=%0d rdy=%b%b want id %0d", k, req0_ready, req1_ready, want_id);
         end
         tick();
         budget = 0;
         @(negedge clk);
         while (!(rsp0_valid || rsp1_valid) && budget < 10) begin
            tick(); @(negedge clk); budget++;
         end
         checks++;
         if (rsp0_valid !== !want_id || rsp1_valid !== want_id ||
             rsp_data !== (want_id ? 32'hFFFFFFFF : 32'h0) || rsp_zero !== !want_id) begin
            failures++;
            $display("FAIL contention_rsp k=%0d rspv=%b%b data=%h zero=%b want id %0d",
                     k, rsp0_valid, rsp1_valid, rsp_data, rsp_zero, want_id);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a0, b0, exp0;
      logic [1:0]   op0;
      a0 = $urandom; b0 = $urandom; op0 = 2'($urandom_range(0, 3));
      exp0 = ref_logic(a0, b0, op0);
      tick();
      req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h2; req1_op = 2'b01;
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept rdy=%b%b want 01", req0_ready, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = a0; req0_b = b0; req0_op = op0;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_exec_ready rdy0=%b want 0", req0_ready);
      end
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== 32'h3 ||
             rsp_zero !== 1'b0 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d rspv=%b%b data=%h zero=%b rdy0=%b want 01 3 0 0",
                     i, rsp0_valid, rsp1_valid, rsp_data, rsp_zero, req0_ready);
         end
         tick();
      end
      rsp1_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp1_valid !== 1'b1 || rsp_data !== 32'h3) begin
         failures++;
         $display("FAIL bp_complete rspv1=%b data=%h want 1 3", rsp1_valid, rsp_data);
      end
      tick();
      rsp1_ready = 1'b0;
      rsp0_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_next_grant rdy0=%b rspv1=%b want 1 0", req0_ready, rsp1_valid);
      end
      tick();
      req0_valid = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp_data !== exp0 || rsp_zero !== (exp0 == '0)) begin
         failures++;
         $display("FAIL bp_req0_result rspv0=%b data=%h zero=%b want 1 %h", rsp0_valid, rsp_data, rsp_zero, exp0);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      int budget;
      tick();
      req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 2'b10;
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_accept rdy1=%b want 1", req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
          rsp_zero !== 1'b1 || rsp_data !== '0) begin
         failures++;
         $display("FAIL rstmid_async busy=%b rspv=%b%b zero=%b data=%h want 0 00 1 0",
                  busy, rsp0_valid, rsp1_valid, rsp_zero, rsp_data);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet cyc=%0d busy=%b rspv=%b%b want 0 00", i, busy, rsp0_valid, rsp1_valid);
         end
         tick();
      end
      req0_valid = 1'b1; req0_a = '1; req0_b = '0; req0_op = 2'b01;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 2'b00;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_prio rdy=%b%b want 10", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      budget = 0;
      @(negedge clk);
      while (!req1_ready && budget < 10) begin
         tick(); @(negedge clk); budget++;
      end
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_drain timeout rdy1=%b want 1", req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      repeat (4) tick();
      idle_inputs();
   endtask

   task automatic test_random();
      bit           pend0, pend1, mbusy, mid, mprio, acc0, acc1, rv0, rv1;
      int           acc_cyc, age;
      logic [W-1:0] got;
      apply_reset();
      exp_q.delete();
      pend0 = 0; pend1 = 0; mbusy = 0; mid = 0; mprio = 0; acc_cyc = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         // drive phase, just after the rising edge
         if (!pend0 && $urandom_range(0, 2) == 0) begin
            pend0 = 1;
            req0_a = $urandom; req0_b = ($urandom_range(0, 4) == 0) ? req0_a : $urandom;
            req0_op = 2'($urandom_range(0, 3));
         end
         if (!pend1 && $urandom_range(0, 2) == 0) begin
            pend1 = 1;
            req1_a = $urandom; req1_b = ($urandom_range(0, 4) == 0) ? ~req1_a : $urandom;
            req1_op = 2'($urandom_range(0, 3));
         end
         req0_valid = pend0;
         req1_valid = pend1;
         rsp0_ready = ($urandom_range(0, 1) == 1);
         rsp1_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         acc0 = !mbusy && pend0 && (!pend1 || mprio == 0);
         acc1 = !mbusy && pend1 && (!pend0 || mprio == 1);
         age  = cyc - acc_cyc;
         rv0  = mbusy && age >= 2 && mid == 0;
         rv1  = mbusy && age >= 2 && mid == 1;
         checks++;
         if (req0_ready !== acc0 || req1_ready !== acc1 || rsp0_valid !== rv0 ||
             rsp1_valid !== rv1 || busy !== mbusy) begin
            failures++;
            $display("FAIL rand_ctrl cyc=%0d rdy=%b%b rspv=%b%b busy=%b want %b%b %b%b %b",
                     cyc, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, acc0, acc1, rv0, rv1, mbusy);
         end
         if ((rv0 || rv1) && exp_q.size() > 0) begin
            got = exp_q[0];
            checks++;
            if (rsp_data !== got || rsp_zero !== (got == '0)) begin
               failures++;
               $display("FAIL rand_data cyc=%0d data=%h zero=%b want %h %b",
                        cyc, rsp_data, rsp_zero, got, (got == '0));
            end
         end
         // model update for the coming edge
         if ((rv0 && rsp0_ready) || (rv1 && rsp1_ready)) begin
            void'(exp_q.pop_front());
            mprio = ~mid;
            mbusy = 0;
         end else if (acc0) begin
            exp_q.push_back(ref_logic(req0_a, req0_b, req0_op));
            mbusy = 1; mid = 0; acc_cyc = cyc; pend0 = 0;
         end else if (acc1) begin
            exp_q.push_back(ref_logic(req1_a, req1_b, req1_op));
            mbusy = 1; mid = 1; acc_cyc = cyc; pend1 = 0;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_xor();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
